// File: rtl/alu_operand_sequencer.sv
// Front-end sequencer for the 3-bit ALU: collects A, B and opcode from one shared bus,
// waits EXEC_LATENCY cycles, then registers the selected unit result until acknowledged.
module alu_operand_sequencer #(
    parameter int unsigned EXEC_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] data_in,
    input  logic       load,
    input  logic       result_ack,
    input  logic [2:0] add_sum,
    input  logic       add_carry,
    input  logic [2:0] or_res,
    input  logic [2:0] and_res,
    input  logic [2:0] xor_res,
    output logic [2:0] op_a,
    output logic [2:0] op_b,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       op_err,
    output logic       busy,
    output logic [1:0] expect_code
);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_OP,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_COUNT = 3'(EXEC_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] opcode;
    logic [2:0] count;
    logic [3:0] sel_result;
    logic       sel_err;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_LOAD_A;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_LOAD_A:  if (load) state_next = S_LOAD_B;
            S_LOAD_B:  if (load) state_next = S_LOAD_OP;
            S_LOAD_OP: if (load) state_next = S_WAIT;
            S_WAIT:    if (count == LAST_COUNT) state_next = S_DONE;
            S_DONE:    if (result_ack) state_next = S_LOAD_A;
            default:   state_next = S_LOAD_A;
        endcase
    end

    // Reserved opcodes (msb set) force a zero result and flag the error.
    always_comb begin
        sel_result = 4'b0000;
        sel_err    = 1'b0;
        if (opcode[2]) begin
            sel_err = 1'b1;
        end else begin
            unique case (opcode[1:0])
                2'b00:   sel_result = {add_carry, add_sum};
                2'b01:   sel_result = {1'b0, or_res};
                2'b10:   sel_result = {1'b0, and_res};
                default: sel_result = {1'b0, xor_res};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a         <= '0;
            op_b         <= '0;
            opcode       <= '0;
            count        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            op_err       <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD_A:  if (load) op_a <= data_in;
                S_LOAD_B:  if (load) op_b <= data_in;
                S_LOAD_OP: if (load) begin
                    opcode <= data_in;
                    count  <= '0;
                end
                S_WAIT: begin
                    count <= count + 3'd1;
                    if (count == LAST_COUNT) begin
                        result       <= sel_result;
                        op_err       <= sel_err;
                        result_valid <= 1'b1;
                    end
                end
                S_DONE:  if (result_ack) result_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy = (state == S_WAIT) || (state == S_DONE);

    always_comb begin
        unique case (state)
            S_LOAD_A:  expect_code = 2'b00;
            S_LOAD_B:  expect_code = 2'b01;
            S_LOAD_OP: expect_code = 2'b10;
            default:   expect_code = 2'b11;
        endcase
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized self-checking bench: two sequencers (latency 1 and 3) with bench-side registered
// function units, compared against an arithmetic model of each transaction.
module tb_alu_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n       [2];
    logic [2:0] data_in     [2];
    logic       load        [2];
    logic       result_ack  [2];
    logic [2:0] add_sum     [2];
    logic       add_carry   [2];
    logic [2:0] or_res      [2];
    logic [2:0] and_res     [2];
    logic [2:0] xor_res     [2];
    logic [2:0] op_a        [2];
    logic [2:0] op_b        [2];
    logic [3:0] result      [2];
    logic       result_valid[2];
    logic       op_err      [2];
    logic       busy        [2];
    logic [1:0] expect_code [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_operand_sequencer #(.EXEC_LATENCY(g == 0 ? 1 : 3)) dut (
            .clk         (clk),
            .rst_n       (rst_n[g]),
            .data_in     (data_in[g]),
            .load        (load[g]),
            .result_ack  (result_ack[g]),
            .add_sum     (add_sum[g]),
            .add_carry   (add_carry[g]),
            .or_res      (or_res[g]),
            .and_res     (and_res[g]),
            .xor_res     (xor_res[g]),
            .op_a        (op_a[g]),
            .op_b        (op_b[g]),
            .result      (result[g]),
            .result_valid(result_valid[g]),
            .op_err      (op_err[g]),
            .busy        (busy[g]),
            .expect_code (expect_code[g])
        );

        // Registered function units fed by the sequencer's operand outputs.
        always @(posedge clk) begin
            {add_carry[g], add_sum[g]} <= {1'b0, op_a[g]} + {1'b0, op_b[g]};
            or_res[g]  <= op_a[g] | op_b[g];
            and_res[g] <= op_a[g] & op_b[g];
            xor_res[g] <= op_a[g] ^ op_b[g];
        end
    end

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Expected {op_err, result} for one transaction.
    function automatic logic [4:0] model(logic [2:0] a, logic [2:0] b, logic [2:0] op);
        int s;
        if (op >= 3'd4) return 5'b1_0000;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                return {1'b0, 4'(s)};
            end
            3'd1:    return {2'b00, a | b};
            3'd2:    return {2'b00, a & b};
            default: return {2'b00, a ^ b};
        endcase
    endfunction

    task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_field(int d, logic [2:0] v);
        data_in[d] = v;
        load[d]    = 1'b1;
        tick();
        load[d]    = 1'b0;
    endtask

    // Enter one operation and wait for its result; leaves the DUT in DONE.
    task automatic run_txn(int d, logic [2:0] a, logic [2:0] b, logic [2:0] op, bit burst);
        logic [4:0] exp;
        int n;
        exp = model(a, b, op);
        check("prompt_a", 8'(expect_code[d]), 8'd0);
        if (burst) begin
            load[d] = 1'b1;
            data_in[d] = a;  tick();
            data_in[d] = b;  tick();
            data_in[d] = op; tick();
            load[d] = 1'b0;
        end else begin
            load_field(d, a);
            repeat ($urandom_range(0, 2)) tick();
            check("prompt_b", 8'(expect_code[d]), 8'd1);
            load_field(d, b);
            repeat ($urandom_range(0, 2)) tick();
            check("prompt_op", 8'(expect_code[d]), 8'd2);
            load_field(d, op);
        end
        check("op_a", 8'(op_a[d]), 8'(a));
        check("op_b", 8'(op_b[d]), 8'(b));
        check("busy_wait", 8'(busy[d]), 8'd1);
        check("prompt_busy", 8'(expect_code[d]), 8'd3);
        n = 0;
        while (!result_valid[d] && n < 20) begin
            tick();
            n++;
        end
        check("latency", 8'(n), 8'(lat_of(d)));
        check("result", 8'(result[d]), 8'(exp[3:0]));
        check("op_err", 8'(op_err[d]), 8'(exp[4]));
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("hold_valid", 8'(result_valid[d]), 8'd1);
            check("hold_result", 8'(result[d]), 8'(exp[3:0]));
        end
    endtask

    task automatic ack_txn(int d, logic [3:0] res, logic err);
        result_ack[d] = 1'b1;
        tick();
        result_ack[d] = 1'b0;
        check("ack_valid", 8'(result_valid[d]), 8'd0);
        check("ack_prompt", 8'(expect_code[d]), 8'd0);
        check("ack_busy", 8'(busy[d]), 8'd0);
        check("ack_result", 8'(result[d]), 8'(res));
        check("ack_err", 8'(op_err[d]), 8'(err));
    endtask

    task automatic check_reset_state(int d);
        check("rst_op_a", 8'(op_a[d]), 8'd0);
        check("rst_op_b", 8'(op_b[d]), 8'd0);
        check("rst_result", 8'(result[d]), 8'd0);
        check("rst_valid", 8'(result_valid[d]), 8'd0);
        check("rst_err", 8'(op_err[d]), 8'd0);
        check("rst_busy", 8'(busy[d]), 8'd0);
        check("rst_prompt", 8'(expect_code[d]), 8'd0);
    endtask

    initial begin
        logic [2:0] a, b, op;
        logic [4:0] e;
        int seen;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; data_in[d] = '0; load[d] = 1'b0; result_ack[d] = 1'b0;
        end
        repeat (2) tick();
        for (int d = 0; d < 2; d++) rst_n[d] = 1'b1;
        for (int d = 0; d < 2; d++) check_reset_state(d);

        // Directed transactions on the latency-1 unit.
        run_txn(0, 3'b101, 3'b011, 3'b001, 1'b0);
        ack_txn(0, 4'b0111, 1'b0);
        run_txn(0, 3'b111, 3'b001, 3'b000, 1'b0);
        ack_txn(0, 4'b1000, 1'b0);
        run_txn(0, 3'b110, 3'b011, 3'b010, 1'b1);
        ack_txn(0, 4'b0010, 1'b0);
        run_txn(0, 3'b110, 3'b011, 3'b011, 1'b1);
        ack_txn(0, 4'b0101, 1'b0);
        run_txn(0, 3'b010, 3'b001, 3'b110, 1'b0);
        ack_txn(0, 4'b0000, 1'b1);
        run_txn(0, 3'b001, 3'b001, 3'b000, 1'b0);
        ack_txn(0, 4'b0010, 1'b0);

        // Acknowledge outside DONE does nothing.
        result_ack[0] = 1'b1; tick(); result_ack[0] = 1'b0;
        check("stray_ack_prompt", 8'(expect_code[0]), 8'd0);
        check("stray_ack_valid", 8'(result_valid[0]), 8'd0);

        // Loads in DONE, including one coincident with ack, are dropped.
        run_txn(0, 3'b011, 3'b100, 3'b011, 1'b0);
        data_in[0] = 3'b010; load[0] = 1'b1;
        repeat (2) tick();
        result_ack[0] = 1'b1; tick();
        load[0] = 1'b0; result_ack[0] = 1'b0;
        check("done_load_op_a", 8'(op_a[0]), 8'(3'b011));
        check("done_load_prompt", 8'(expect_code[0]), 8'd0);
        check("done_load_valid", 8'(result_valid[0]), 8'd0);
        load_field(0, 3'b100);
        check("reload_op_a", 8'(op_a[0]), 8'(3'b100));
        check("reload_prompt", 8'(expect_code[0]), 8'd1);
        load_field(0, 3'b001);
        load_field(0, 3'b010);
        tick();
        check("reload_result", 8'(result[0]), 8'(3'b000));
        ack_txn(0, 4'b0000, 1'b0);

        // Latency-3 unit: normal operation, then reset on the second WAIT edge.
        run_txn(1, 3'b101, 3'b110, 3'b000, 1'b1);
        ack_txn(1, 4'b1011, 1'b0);
        load_field(1, 3'b011);
        load_field(1, 3'b010);
        load_field(1, 3'b011);
        tick();
        rst_n[1] = 1'b0;
        tick();
        rst_n[1] = 1'b1;
        check_reset_state(1);
        seen = 0;
        repeat (6) begin
            tick();
            if (result_valid[1]) seen++;
        end
        check("no_valid_after_rst", 8'(seen), 8'd0);

        // Randomized transactions on both units.
        for (int i = 0; i < 60; i++) begin
            int d;
            d  = i % 2;
            a  = 3'($urandom);
            b  = 3'($urandom);
            op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            e  = model(a, b, op);
            run_txn(d, a, b, op, 1'($urandom));
            ack_txn(d, e[3:0], e[4]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
